// File: rtl/parity_pkg.sv
// Shared types and helpers for the odd-parity receive path.
// Holds word widths, the parity predicate and the FIFO occupancy states.
package parity_pkg;

    localparam int WORD_W = 16;
    localparam int DATA_W = 15;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    // A protected word is good when all 16 bits XOR to 1.
    function automatic logic odd_parity_ok(input logic [WORD_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/parity_rx_fifo2.sv
// Two-entry valid/ready FIFO with an explicit EMPTY/ONE/FULL occupancy FSM.
// Ports: wr_valid_i/wr_ready_o/wr_data_i in, rd_valid_o/rd_ready_i/rd_data_o out.
module parity_rx_fifo2
    import parity_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    input  logic [WORD_W-1:0] wr_data_i,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic [WORD_W-1:0] rd_data_o
);

    occ_e              state_q, state_d;
    logic [WORD_W-1:0] head_q, head_d;
    logic [WORD_W-1:0] tail_q, tail_d;
    logic              push;
    logic              pop;

    // Ready depends only on registered occupancy: no ready path through.
    assign wr_ready_o = (state_q != FULL);
    assign rd_valid_o = (state_q != EMPTY);
    assign rd_data_o  = rd_valid_o ? head_q : '0;

    assign push = wr_valid_i && wr_ready_o;
    assign pop  = rd_valid_o && rd_ready_i;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d  = wr_data_i;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_d = wr_data_i;
                end else if (push) begin
                    tail_d  = wr_data_i;
                    state_d = FULL;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: rtl/parity_check_rx.sv
// Odd-parity word checker: strips bit 0, queues payload, keeps error stats.
// Ports: in_* / out_* valid-ready streams, err_sticky/err_clr/err_count; macro PARITY_ERR_CNT_EN.
module parity_check_rx
    import parity_pkg::*;
#(
    parameter int DROP_BAD  = 0,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_W-1:0]    in_word,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_perr,
    output logic                 err_sticky,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_count
);

    logic              bad;
    logic              accept;
    logic              wr_valid;
    logic [WORD_W-1:0] rd_data;
    logic              sticky_q, sticky_d;

    assign bad    = !odd_parity_ok(in_word);
    assign accept = in_valid && in_ready;

    // Dropped words still handshake; they just never reach the FIFO.
    assign wr_valid = in_valid && !((DROP_BAD != 0) && bad);

    parity_rx_fifo2 u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .wr_valid_i (wr_valid),
        .wr_ready_o (in_ready),
        .wr_data_i  ({bad, in_word[WORD_W-1:1]}),
        .rd_valid_o (out_valid),
        .rd_ready_i (out_ready),
        .rd_data_o  (rd_data)
    );

    assign out_perr = rd_data[WORD_W-1];
    assign out_data = rd_data[DATA_W-1:0];

    // Clear has priority over a same-cycle bad accept.
    always_comb begin
        sticky_d = sticky_q;
        if (err_clr) begin
            sticky_d = 1'b0;
        end else if (accept && bad) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign err_sticky = sticky_q;

`ifdef PARITY_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (err_clr) begin
            cnt_d = '0;
        end else if (accept && bad && (cnt_q != '1)) begin
            cnt_d = cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign err_count = cnt_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_parity_check_rx.sv
// Self-checking bench for parity_check_rx, DROP_BAD=0 and DROP_BAD=1 instances.
// Reference model: per-instance payload queue plus error counter/sticky flag.
module tb_parity_check_rx;

`ifdef PARITY_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [1:0]       iv, ordy, clr;
    logic [1:0][15:0] iw;
    logic [1:0]       ir, ov, op, es;
    logic [1:0][14:0] od;
    logic [1:0][7:0]  ec;

    parity_check_rx #(.DROP_BAD(0), .ERR_CNT_W(8)) dut0 (
        .clock(clk), .reset_n(rst_n),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_word(iw[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]),
        .out_data(od[0]), .out_perr(op[0]),
        .err_sticky(es[0]), .err_clr(clr[0]), .err_count(ec[0])
    );

    parity_check_rx #(.DROP_BAD(1), .ERR_CNT_W(8)) dut1 (
        .clock(clk), .reset_n(rst_n),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_word(iw[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]),
        .out_data(od[1]), .out_perr(op[1]),
        .err_sticky(es[1]), .err_clr(clr[1]), .err_count(ec[1])
    );

    // Model entries: {payload[14:0], perr}
    logic [15:0] mq0[$];
    logic [15:0] mq1[$];
    int          mcnt[2];
    bit          mst[2];
    bit          macc[2];

    int n_vec = 0;
    int n_mis = 0;

    function automatic int msize(int d);
        return (d == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic logic [15:0] mhead(int d);
        if (msize(d) == 0) return 16'h0;
        return (d == 0) ? mq0[0] : mq1[0];
    endfunction

    function automatic logic [15:0] good_word(logic [14:0] p);
        return {p, ~(^p)};
    endfunction

    function automatic logic [15:0] bad_word(logic [14:0] p);
        return {p, ^p};
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(int d);
        logic [15:0] h;
        h = mhead(d);
        check($sformatf("in_ready[%0d]", d), 32'(ir[d]), 32'(msize(d) < 2));
        check($sformatf("out_valid[%0d]", d), 32'(ov[d]), 32'(msize(d) > 0));
        check($sformatf("out_data[%0d]", d), 32'(od[d]), 32'(h[15:1]));
        check($sformatf("out_perr[%0d]", d), 32'(op[d]), 32'(h[0]));
        check($sformatf("err_sticky[%0d]", d), 32'(es[d]), 32'(mst[d]));
        check($sformatf("err_count[%0d]", d), 32'(ec[d]),
              CNT_EN ? 32'(mcnt[d]) : 32'd0);
    endtask

    task automatic model_edge(int d);
        bit bad, acc, pop;
        bad = (^iw[d]) == 1'b0;
        acc = iv[d] && (msize(d) < 2);
        pop = ordy[d] && (msize(d) > 0);
        macc[d] = acc;
        if (pop) begin
            if (d == 0) void'(mq0.pop_front());
            else        void'(mq1.pop_front());
        end
        if (acc && !(d == 1 && bad)) begin
            if (d == 0) mq0.push_back({iw[d][15:1], bad});
            else        mq1.push_back({iw[d][15:1], bad});
        end
        if (clr[d]) begin
            mcnt[d] = 0;
            mst[d]  = 0;
        end else if (acc && bad) begin
            mst[d] = 1;
            if (mcnt[d] < 255) mcnt[d]++;
        end
    endtask

    // Called at a negedge with inputs already set; advances one cycle.
    task automatic tick();
        for (int d = 0; d < 2; d++) begin
            if (rst_n) begin
                chk_state(d);
                model_edge(d);
            end else begin
                macc[d] = 0;
            end
        end
        if (!rst_n) begin
            mq0.delete();
            mq1.delete();
            mcnt = '{0, 0};
            mst  = '{0, 0};
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(int d, bit v, logic [15:0] w, bit r, bit c);
        iv[d]   = v;
        iw[d]   = w;
        ordy[d] = r;
        clr[d]  = c;
    endtask

    task automatic send(int d, logic [15:0] w, bit r);
        int k;
        drive(d, 1'b1, w, r, 1'b0);
        k = 0;
        macc[d] = 0;
        while (!macc[d] && k < 20) begin
            tick();
            k++;
        end
        check($sformatf("send_accept[%0d]", d), 32'(macc[d]), 32'd1);
        drive(d, 1'b0, 16'h0, r, 1'b0);
    endtask

    bit          pend[2];
    logic [15:0] pw[2];

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 16'h0, 1, 0);
        drive(1, 0, 16'h0, 1, 0);
        @(negedge clk);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Basic good word, payload 0
        send(0, 16'h0001, 1'b1);
        check("plan_0001_data", 32'(od[0]), 32'h0);
        check("plan_0001_perr", 32'(op[0]), 32'h0);
        check("plan_0001_valid", 32'(ov[0]), 32'h1);
        tick();

        send(0, 16'hFFFE, 1'b1);
        check("plan_fffe_data", 32'(od[0]), 32'h7FFF);
        check("plan_fffe_perr", 32'(op[0]), 32'h0);
        tick();

        // Two bad words queued with perr
        send(0, 16'h0000, 1'b1);
        check("plan_0000_perr", 32'(op[0]), 32'h1);
        send(0, 16'hFFFF, 1'b1);
        check("plan_ffff_data", 32'(od[0]), 32'h7FFF);
        check("plan_ffff_perr", 32'(op[0]), 32'h1);
        tick();
        check("plan_cnt2", 32'(ec[0]), CNT_EN ? 32'd2 : 32'd0);
        check("plan_sticky", 32'(es[0]), 32'd1);

        // Backpressure: two fit, third stalls
        send(0, good_word(15'h1111), 1'b0);
        send(0, good_word(15'h2222), 1'b0);
        drive(0, 1, good_word(15'h3333), 0, 0);
        tick();
        tick();
        check("full_in_ready", 32'(ir[0]), 32'd0);
        tick();
        drive(0, 1, good_word(15'h3333), 1, 0);
        check("full_head", 32'(od[0]), 32'h1111);
        tick();
        check("stall_accept_none", 32'(macc[0]), 32'd0);
        check("next_head", 32'(od[0]), 32'h2222);
        tick();
        check("stall_accept", 32'(macc[0]), 32'd1);
        drive(0, 0, 16'h0, 1, 0);
        check("third_head", 32'(od[0]), 32'h3333);
        tick();
        tick();

        // Randomized traffic on both instances, hold rule honoured
        pend = '{0, 0};
        for (int c = 0; c < 400; c++) begin
            for (int d = 0; d < 2; d++) begin
                if (!pend[d] && ($urandom % 3 == 0)) begin
                    pend[d] = 1;
                    pw[d]   = 16'($urandom);
                end
                drive(d, pend[d], pend[d] ? pw[d] : 16'($urandom),
                      1'($urandom % 2), ($urandom % 24) == 0);
            end
            tick();
            for (int d = 0; d < 2; d++)
                if (macc[d]) pend[d] = 0;
        end
        drive(0, 0, 16'h0, 1, 0);
        drive(1, 0, 16'h0, 1, 0);
        tick();
        tick();
        tick();

        // Saturation with DROP_BAD=1
        drive(1, 0, 16'h0, 1, 1);
        tick();
        for (int i = 0; i < 300; i++)
            send(1, bad_word(15'($urandom)), 1'b1);
        tick();
        check("sat_count", 32'(ec[1]), CNT_EN ? 32'd255 : 32'd0);
        check("sat_sticky", 32'(es[1]), 32'd1);
        check("sat_no_valid", 32'(ov[1]), 32'd0);

        // Clear wins over a same-cycle bad accept
        drive(1, 1, bad_word(15'h0ABC), 1, 1);
        tick();
        drive(1, 0, 16'h0, 1, 0);
        check("clr_count", 32'(ec[1]), 32'd0);
        check("clr_sticky", 32'(es[1]), 32'd0);
        tick();

        // Fill to FULL then reset one cycle
        send(0, bad_word(15'h0055), 1'b0);
        send(0, good_word(15'h00AA), 1'b0);
        tick();
        check("pre_rst_full", 32'(ir[0]), 32'd0);
        drive(0, 1, good_word(15'h0F0F), 0, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive(0, 0, 16'h0, 1, 0);
        check("rst_out_valid", 32'(ov[0]), 32'd0);
        check("rst_in_ready", 32'(ir[0]), 32'd1);
        check("rst_sticky", 32'(es[0]), 32'd0);
        check("rst_count", 32'(ec[0]), 32'd0);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
